// File: rtl/alu_exec_if.sv
// Handshake and operand/result bundle between the control unit and the execution ALU.
interface alu_exec_if #(
   parameter int unsigned WIDTH = 32
);
   logic             start;
   logic [2:0]       ALU_aluOp;
   logic [WIDTH-1:0] opA;
   logic [WIDTH-1:0] opB;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             busy;
   logic             done;
   logic             div_by_zero;

   // Control unit side: issues requests, observes results.
   modport master (
      output start, ALU_aluOp, opA, opB,
      input  result, zero, hi, lo, busy, done, div_by_zero
   );

   // ALU side.
   modport slave (
      input  start, ALU_aluOp, opA, opB,
      output result, zero, hi, lo, busy, done, div_by_zero
   );
endinterface

// File: rtl/alu_exec.sv
// Execution-stage ALU: single-cycle logic/arith ops, iterative MULT/DIV into HI/LO.
module alu_exec #(
   parameter int unsigned WIDTH = 32
) (
   input  logic       clk,
   input  logic       reset,
   alu_exec_if.slave  bus
);
   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [2:0] OP_AND  = 3'b000;
   localparam logic [2:0] OP_OR   = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_SLT  = 3'b100;
   localparam logic [2:0] OP_DIV  = 3'b101;
   localparam logic [2:0] OP_MULT = 3'b111;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_e;

   state_e               state_q, state_d;
   logic [WIDTH-1:0]     result_q, result_d;
   logic [WIDTH-1:0]     hi_q, hi_d;
   logic [WIDTH-1:0]     lo_q, lo_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 dbz_q, dbz_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [2*WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]     mplier_q, mplier_d;
   logic [WIDTH-1:0]     rem_q, rem_d;
   logic [WIDTH-1:0]     quo_q, quo_d;
   logic [WIDTH-1:0]     dvsr_q, dvsr_d;

   logic [2*WIDTH-1:0]   acc_nxt;
   logic [WIDTH:0]       rem_sh;
   logic [WIDTH:0]       diff;
   logic [WIDTH-1:0]     rem_nxt;
   logic [WIDTH-1:0]     quo_nxt;
   logic                 last;

   // Next-state, datapath step and result selection.
   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      dbz_d    = dbz_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      dvsr_d   = dvsr_q;

      // One shift-add step and one restoring-division step, used by the iterating states.
      acc_nxt = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
      rem_sh  = {rem_q, quo_q[WIDTH-1]};
      diff    = rem_sh - {1'b0, dvsr_q};
      if (!diff[WIDTH]) begin
         rem_nxt = diff[WIDTH-1:0];
         quo_nxt = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
         rem_nxt = rem_sh[WIDTH-1:0];
         quo_nxt = {quo_q[WIDTH-2:0], 1'b0};
      end
      last = (cnt_q == CW'(WIDTH - 1));

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               dbz_d  = 1'b0;
               done_d = 1'b1;
               case (bus.ALU_aluOp)
                  OP_AND:  result_d = bus.opA & bus.opB;
                  OP_OR:   result_d = bus.opA | bus.opB;
                  OP_ADD:  result_d = bus.opA + bus.opB;
                  OP_SUB:  result_d = bus.opA - bus.opB;
                  OP_SLT:  result_d = {{(WIDTH-1){1'b0}}, ($signed(bus.opA) < $signed(bus.opB))};
                  OP_MULT: begin
                     done_d   = 1'b0;
                     busy_d   = 1'b1;
                     state_d  = S_MUL;
                     acc_d    = '0;
                     mcand_d  = {{WIDTH{1'b0}}, bus.opA};
                     mplier_d = bus.opB;
                     cnt_d    = '0;
                  end
                  OP_DIV: begin
                     if (bus.opB == '0) begin
                        result_d = '1;
                        lo_d     = '1;
                        hi_d     = bus.opA;
                        dbz_d    = 1'b1;
                     end else begin
                        done_d  = 1'b0;
                        busy_d  = 1'b1;
                        state_d = S_DIV;
                        rem_d   = '0;
                        quo_d   = bus.opA;
                        dvsr_d  = bus.opB;
                        cnt_d   = '0;
                     end
                  end
                  default: result_d = '0;
               endcase
            end
         end
         S_MUL: begin
            acc_d    = acc_nxt;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (last) begin
               {hi_d, lo_d} = acc_nxt;
               result_d     = acc_nxt[WIDTH-1:0];
               done_d       = 1'b1;
               busy_d       = 1'b0;
               state_d      = S_IDLE;
            end
         end
         S_DIV: begin
            rem_d = rem_nxt;
            quo_d = quo_nxt;
            cnt_d = cnt_q + CW'(1);
            if (last) begin
               hi_d     = rem_nxt;
               lo_d     = quo_nxt;
               result_d = quo_nxt;
               done_d   = 1'b1;
               busy_d   = 1'b0;
               state_d  = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers; synchronous reset aborts any in-flight op.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         result_q <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         dbz_q    <= 1'b0;
         cnt_q    <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         dvsr_q   <= '0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         dbz_q    <= dbz_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         dvsr_q   <= dvsr_d;
      end
   end

   assign bus.result      = result_q;
   assign bus.zero        = (result_q == '0);
   assign bus.hi          = hi_q;
   assign bus.lo          = lo_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_alu_exec.sv
// Scoreboard bench for alu_exec: expectations queued at issue, checked on each done pulse.
module tb_alu_exec;
   localparam int unsigned W = 32;

   localparam logic [2:0] AND_ = 3'b000, OR_ = 3'b001, ADD = 3'b010, SUB = 3'b011;
   localparam logic [2:0] SLT = 3'b100, DIV = 3'b101, NOP = 3'b110, MUL = 3'b111;

   typedef struct {
      logic [W-1:0] res;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dbz;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   exp_t sb[$];
   exp_t mon_e;
   logic [W-1:0] m_hi, m_lo;
   int total = 0;
   int bad = 0;

   alu_exec_if #(.WIDTH(W)) bus();
   alu_exec #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Build the expected outcome, queue it, then drive a one-cycle start from a negedge.
   task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      logic [2*W-1:0] aa, bb, p;
      e.hi = m_hi; e.lo = m_lo; e.dbz = 1'b0; e.res = '0;
      aa = '0; bb = '0; aa[W-1:0] = a; bb[W-1:0] = b;
      case (op)
         AND_: e.res = a & b;
         OR_:  e.res = a | b;
         ADD:  e.res = a + b;
         SUB:  e.res = a - b;
         SLT:  e.res = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
         DIV: begin
            if (b == '0) begin
               e.res = '1; e.lo = '1; e.hi = a; e.dbz = 1'b1;
            end else begin
               e.res = a / b; e.lo = a / b; e.hi = a % b;
            end
         end
         MUL: begin
            p = aa * bb;
            e.hi = p[2*W-1:W]; e.lo = p[W-1:0]; e.res = p[W-1:0];
         end
         default: e.res = '0;
      endcase
      m_hi = e.hi; m_lo = e.lo;
      sb.push_back(e);
      bus.start = 1'b1; bus.ALU_aluOp = op; bus.opA = a; bus.opB = b;
      @(negedge clk);
      bus.start = 1'b0;
      bus.opA = $urandom; bus.opB = $urandom; bus.ALU_aluOp = 3'($urandom);
   endtask

   // Called at the negedge after acceptance; lat=1 means done already visible there.
   task automatic wait_done(input string tag, input int budget, output int lat, output int bc);
      lat = 1; bc = 0;
      while (!bus.done && lat <= budget) begin
         if (bus.busy) bc++;
         @(negedge clk);
         lat++;
      end
      if (!bus.done) chk({tag, "_timeout"}, 64'(bus.done), 64'(1));
   endtask

   task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input int exp_lat);
      int lat, bc;
      issue(op, a, b);
      wait_done(tag, 2 * W, lat, bc);
      chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      chk({tag, "_busy"}, 64'(bc), 64'(exp_lat - 1));
      @(negedge clk);
      chk({tag, "_pulse"}, 64'(bus.done), 64'(0));
   endtask

   // Every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!reset && bus.done) begin
         if (sb.size() == 0) begin
            chk("spurious_done", 64'(bus.done), 64'(0));
         end else begin
            mon_e = sb.pop_front();
            chk("result", 64'(bus.result), 64'(mon_e.res));
            chk("hi", 64'(bus.hi), 64'(mon_e.hi));
            chk("lo", 64'(bus.lo), 64'(mon_e.lo));
            chk("dbz", 64'(bus.div_by_zero), 64'(mon_e.dbz));
            chk("zero", 64'(bus.zero), 64'(mon_e.res == '0));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   task automatic chk_cleared(input string tag);
      chk({tag, "_result"}, 64'(bus.result), 64'(0));
      chk({tag, "_hi"}, 64'(bus.hi), 64'(0));
      chk({tag, "_lo"}, 64'(bus.lo), 64'(0));
      chk({tag, "_busy"}, 64'(bus.busy), 64'(0));
      chk({tag, "_done"}, 64'(bus.done), 64'(0));
      chk({tag, "_dbz"}, 64'(bus.div_by_zero), 64'(0));
      chk({tag, "_zero"}, 64'(bus.zero), 64'(1));
   endtask

   initial begin
      int lat, bc;
      logic [2:0] rop;
      logic [W-1:0] ra, rb;
      reset = 1'b1;
      bus.start = 1'b0; bus.ALU_aluOp = ADD; bus.opA = '0; bus.opB = '0;
      m_hi = '0; m_lo = '0;
      repeat (2) @(negedge clk);
      chk_cleared("rst");
      reset = 1'b0;
      @(negedge clk);

      // Single-cycle ops.
      issue(ADD, 32'd5, 32'd7);
      chk("add_done", 64'(bus.done), 64'(1));
      chk("add_busy0", 64'(bus.busy), 64'(0));
      chk("add_zero", 64'(bus.zero), 64'(0));
      @(negedge clk);
      chk("add_pulse", 64'(bus.done), 64'(0));
      run_op("sub", SUB, 32'd3, 32'd3, 1);
      run_op("slt_neg", SLT, 32'hFFFF_FFFF, 32'd1, 1);
      run_op("slt_pos", SLT, 32'd1, 32'hFFFF_FFFF, 1);
      run_op("and", AND_, 32'hF0F0_1234, 32'h0FF0_FF00, 1);
      run_op("or", OR_, 32'hF0F0_1234, 32'h0FF0_FF00, 1);
      run_op("nop", NOP, 32'h1234_5678, 32'h9ABC_DEF0, 1);
      run_op("add_wrap", ADD, 32'hFFFF_FFFF, 32'd2, 1);

      // MULT with an ADD attempted mid-operation; the ADD must be ignored.
      issue(MUL, 32'hFFFF_FFFF, 32'd2);
      repeat (5) @(negedge clk);
      bus.start = 1'b1; bus.ALU_aluOp = ADD; bus.opA = 32'd1; bus.opB = 32'd1;
      @(negedge clk);
      bus.start = 1'b0;
      chk("mul_busy_mid", 64'(bus.busy), 64'(1));
      wait_done("mul", 2 * W, lat, bc);
      chk("mul_lat", 64'(lat + 6), 64'(W + 1));
      repeat (3) @(negedge clk);
      chk("mul_no_extra", 64'(sb.size()), 64'(0));

      // Division, normal and by zero.
      run_op("div", DIV, 32'd100, 32'd7, W + 1);
      run_op("div0", DIV, 32'd9, 32'd0, 1);
      run_op("div_after0", DIV, 32'hFFFF_FFFF, 32'hFFFF_FFFF, W + 1);

      // Random mix.
      for (int i = 0; i < 10; i++) begin
         rop = 3'($urandom_range(0, 7));
         ra = $urandom;
         rb = (i == 3) ? '0 : W'($urandom);
         run_op("rand", rop, ra, rb,
                (rop == MUL || (rop == DIV && rb != '0)) ? W + 1 : 1);
      end

      // Reset during MULT aborts with no done.
      issue(MUL, 32'h1234, 32'h5678);
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      sb.delete();
      m_hi = '0; m_lo = '0;
      chk_cleared("abort");
      repeat (40) @(negedge clk);
      chk("abort_idle", 64'(bus.busy), 64'(0));
      run_op("post_rst_add", ADD, 32'd1, 32'd1, 1);

      // Back-to-back: ADD issued in the MULT done cycle.
      issue(MUL, 32'd3, 32'd4);
      wait_done("b2b_mul", 2 * W, lat, bc);
      chk("b2b_mul_lat", 64'(lat), 64'(W + 1));
      issue(ADD, 32'd2, 32'd2);
      chk("b2b_add_done", 64'(bus.done), 64'(1));
      chk("b2b_add_res", 64'(bus.result), 64'(4));
      chk("b2b_lo_kept", 64'(bus.lo), 64'(12));
      @(negedge clk);
      chk("b2b_pulse", 64'(bus.done), 64'(0));

      repeat (3) @(negedge clk);
      chk("sb_empty", 64'(sb.size()), 64'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/alu_exec.md
Name: alu_exec

Overview:
- Execution-stage ALU that consumes the 3-bit ALU_aluOp code produced by the ALU control decoder, plus two register operands.
- AND/OR/ADD/SUB/SLT/NOP complete in one cycle.
- MULT and DIV run on an iterative shift-add / restoring datapath and write the HI/LO registers.
- A start/busy/done handshake lets the control unit stall the pipeline while MULT/DIV iterate.

Parameters:
- WIDTH, 32, operand/result width; iteration count for MULT and DIV.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- ALU_aluOp  input  3  000 AND, 001 OR, 010 ADD, 011 SUB, 100 SLT, 101 DIV, 110 NOP, 111 MULT
- opA  input  WIDTH  operand A / multiplicand / dividend
- opB  input  WIDTH  operand B / multiplier / divisor
- result  output  WIDTH  registered result
- zero  output  1  combinational (result == 0)
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register
- busy  output  1  multi-cycle op in progress
- done  output  1  one-cycle pulse; result/hi/lo valid
- div_by_zero  output  1  registered flag, updated with each done

Behaviour:
- Reset, sampled on clk: result=0, hi=0, lo=0, busy=0, done=0, div_by_zero=0, FSM=IDLE. zero therefore reads 1.
- Reset during MULT/DIV aborts the operation; no done pulse; partial values discarded.
- FSM states: IDLE, MUL, DIV.
- Accept: start=1 and FSM=IDLE at edge E. Operands and op are captured at E.
- start while busy=1 is ignored; it is not queued.
- Single-cycle ops, at edge E:
  - result written; done=1 for the following cycle; busy stays 0; div_by_zero=0.
  - AND/OR: bitwise.
  - ADD/SUB: modulo 2^WIDTH, no overflow flag.
  - SLT: signed two's-complement compare; result=1 if opA<opB, else 0.
  - NOP: result=0.
  - hi/lo unchanged for all single-cycle ops.
- MULT (unsigned):
  - At E: load multiplicand, multiplier, 2*WIDTH accumulator=0, counter=0; FSM->MUL; busy=1.
  - Each edge in MUL performs one shift-add step.
  - At edge E+WIDTH: {hi,lo}=opA*opB (full 2*WIDTH product), result=lo, done=1, busy=0, FSM->IDLE.
- DIV (unsigned restoring):
  - At E: if opB==0, take the divide-by-zero path (below). Otherwise FSM->DIV and busy=1.
  - Each edge in DIV performs one shift/trial-subtract step.
  - At edge E+WIDTH: lo=quotient, hi=remainder, result=quotient, done=1, busy=0, FSM->IDLE.
- Divide by zero: at E, lo=all ones, hi=opA, result=all ones, div_by_zero=1, done=1 the next cycle, busy stays 0.
- done is high for exactly one cycle per accepted op.
- Back-to-back ops: in the cycle done=1 the FSM is IDLE, so start=1 in that cycle is accepted.
- Operand inputs may change after E without affecting an in-flight op.
- Unknown encodings: none; all 8 codes are defined.

Test Plan:
- Reset, then ADD opA=5 opB=7 -> next cycle result=12, done=1 for one cycle, busy=0, zero=0.
- SUB opA=3 opB=3 -> result=0, zero=1. SLT opA=0xFFFFFFFF opB=1 -> result=1. SLT opA=1 opB=0xFFFFFFFF -> result=0.
- MULT opA=0xFFFFFFFF opB=2 -> busy=1 for 32 cycles; done at E+32; hi=0x00000001, lo=0xFFFFFFFE, result=0xFFFFFFFE. An ADD issued mid-operation is ignored.
- DIV opA=100 opB=7 -> done at E+32; lo=14, hi=2, div_by_zero=0. Then DIV opA=9 opB=0 -> done next cycle, lo=0xFFFFFFFF, hi=9, div_by_zero=1, busy never 1.
- MULT started, reset asserted 10 cycles later -> next cycle all outputs 0, busy=0, no done. A fresh ADD 1+1 -> result=2.
- MULT 3*4 with an ADD 2+2 issued in the done cycle -> lo=12; the following cycle result=4, done=1, hi/lo unchanged.
